// File: rtl/uart_pkg.sv
// Shared types and constants for the UART frame controller.
// No logic; the defaults assume 16x oversampling and 10-bit characters.
package uart_pkg;

    localparam int OVERSAMPLE        = 16;
    localparam int BITS_PER_CHAR     = 10;
    localparam int TIMEOUT_CHARS     = 4;
    localparam int TIMEOUT_TICKS_DEF = TIMEOUT_CHARS * BITS_PER_CHAR * OVERSAMPLE;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    typedef enum logic [2:0] {
        HUNT,
        CMD,
        LEN,
        PAYLOAD,
        CHK,
        EMIT
    } frame_state_t;

    typedef enum logic [1:0] {
        ERR_OVERRUN  = 2'd0,
        ERR_CHECKSUM = 2'd1,
        ERR_LENGTH   = 2'd2,
        ERR_TIMEOUT  = 2'd3
    } frame_err_t;

endpackage

// File: rtl/uart_frame_ctrl_frame_buf.sv
// Payload store: write lands on the next clk edge, read is combinational.
// No backpressure; the controller never writes past the frame length.
module frame_buf #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 8,
    parameter int AW         = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_idx,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [AW-1:0]         rd_idx,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_idx] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/uart_frame_ctrl.sv
// Frames rx bytes (SYNC,CMD,LEN,payload,CHK) into checked beats; outputs are registered, one edge after the byte.
// Output beats hold while out_ready is low; bytes arriving during emission are dropped with an overrun error.
module uart_frame_ctrl
    import uart_pkg::*;
#(
    parameter int                   DATA_WIDTH    = 8,
    parameter int                   MAX_LEN       = 16,
    parameter logic [DATA_WIDTH-1:0] SYNC_BYTE    = SYNC_BYTE_DEF,
    parameter int                   TIMEOUT_TICKS = TIMEOUT_TICKS_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic                  rx_done,
    input  logic [DATA_WIDTH-1:0] rx_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_sof,
    output logic                  out_eof,
    output logic [7:0]            out_len,
    output logic                  err_valid,
    output logic [1:0]            err_code,
    output logic                  busy
);

    localparam int IW = $clog2(MAX_LEN + 1);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [DATA_WIDTH-1:0] MAX_LEN_B = DATA_WIDTH'(MAX_LEN);
    localparam logic [TW-1:0]         TMO_LAST  = TW'(TIMEOUT_TICKS - 1);

    frame_state_t          state_q, state_d;
    logic [DATA_WIDTH-1:0] opcode_q, opcode_d;
    logic [DATA_WIDTH-1:0] chk_q, chk_d;
    logic [7:0]            len_q, len_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [IW-1:0]         beat_q, beat_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_sof_q, out_sof_d;
    logic                  out_eof_q, out_eof_d;
    logic                  err_valid_q, err_valid_d;
    frame_err_t            err_code_q, err_code_d;
    logic                  busy_q, busy_d;

    logic                  buf_wr_en;
    logic [DATA_WIDTH-1:0] buf_rd_data;

    frame_buf #(
        .DEPTH      (MAX_LEN),
        .DATA_WIDTH (DATA_WIDTH),
        .AW         (AW)
    ) u_frame_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (buf_wr_en),
        .wr_idx  (idx_q[AW-1:0]),
        .wr_data (rx_data),
        .rd_idx  (beat_q[AW-1:0]),
        .rd_data (buf_rd_data)
    );

    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        chk_d       = chk_q;
        len_d       = len_q;
        idx_d       = idx_q;
        beat_d      = beat_q;
        tmo_d       = tmo_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sof_d   = out_sof_q;
        out_eof_d   = out_eof_q;
        err_valid_d = 1'b0;
        err_code_d  = err_code_q;
        buf_wr_en   = 1'b0;

        case (state_q)
            HUNT: begin
                if (rx_done && rx_data == SYNC_BYTE) begin
                    state_d = CMD;
                end
            end
            CMD: begin
                if (rx_done) begin
                    opcode_d = rx_data;
                    chk_d    = rx_data;
                    state_d  = LEN;
                end
            end
            LEN: begin
                if (rx_done) begin
                    if (rx_data > MAX_LEN_B) begin
                        err_valid_d = 1'b1;
                        err_code_d  = ERR_LENGTH;
                        state_d     = HUNT;
                    end else begin
                        len_d   = rx_data;
                        chk_d   = chk_q ^ rx_data;
                        idx_d   = '0;
                        state_d = (rx_data == '0) ? CHK : PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (rx_done) begin
                    buf_wr_en = 1'b1;
                    chk_d     = chk_q ^ rx_data;
                    idx_d     = idx_q + IW'(1);
                    if (8'(idx_q) + 8'd1 == len_q) begin
                        state_d = CHK;
                    end
                end
            end
            CHK: begin
                if (rx_done) begin
                    if (rx_data == chk_q) begin
                        state_d     = EMIT;
                        beat_d      = '0;
                        out_valid_d = 1'b1;
                        out_data_d  = opcode_q;
                        out_sof_d   = 1'b1;
                        out_eof_d   = (len_q == 8'd0);
                    end else begin
                        err_valid_d = 1'b1;
                        err_code_d  = ERR_CHECKSUM;
                        state_d     = HUNT;
                    end
                end
            end
            EMIT: begin
                if (rx_done) begin
                    err_valid_d = 1'b1;
                    err_code_d  = ERR_OVERRUN;
                end
                if (out_valid_q && out_ready) begin
                    if (out_eof_q) begin
                        out_valid_d = 1'b0;
                        out_sof_d   = 1'b0;
                        out_eof_d   = 1'b0;
                        state_d     = HUNT;
                    end else begin
                        // Next beat k = beat_q+1 carries payload byte k-1, i.e. buf[beat_q].
                        beat_d     = beat_q + IW'(1);
                        out_data_d = buf_rd_data;
                        out_sof_d  = 1'b0;
                        out_eof_d  = (8'(beat_q) + 8'd1 == len_q);
                    end
                end
            end
            default: state_d = HUNT;
        endcase

        // A byte in the same cycle as the terminal tick keeps the frame alive.
        if (state_q inside {CMD, LEN, PAYLOAD, CHK}) begin
            if (rx_done) begin
                tmo_d = '0;
            end else if (tick) begin
                if (tmo_q == TMO_LAST) begin
                    tmo_d       = '0;
                    state_d     = HUNT;
                    err_valid_d = 1'b1;
                    err_code_d  = ERR_TIMEOUT;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
        end else begin
            tmo_d = '0;
        end

        busy_d = (state_d != HUNT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HUNT;
            opcode_q    <= '0;
            chk_q       <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            beat_q      <= '0;
            tmo_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            err_valid_q <= 1'b0;
            err_code_q  <= ERR_OVERRUN;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            chk_q       <= chk_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            beat_q      <= beat_d;
            tmo_q       <= tmo_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sof_q   <= out_sof_d;
            out_eof_q   <= out_eof_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
            busy_q      <= busy_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sof   = out_sof_q;
    assign out_eof   = out_eof_q;
    assign out_len   = len_q;
    assign err_valid = err_valid_q;
    assign err_code  = err_code_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Bench for uart_frame_ctrl: table of byte-level frames plus hand sequences
// for timeout, stall/overrun, max length and mid-frame reset.
module tb_uart_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       rx_done;
    logic [7:0] rx_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_sof;
    logic       out_eof;
    logic [7:0] out_len;
    logic       err_valid;
    logic [1:0] err_code;
    logic       busy;

    always #5 clk = ~clk;

    uart_frame_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .rx_done   (rx_done),
        .rx_data   (rx_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sof   (out_sof),
        .out_eof   (out_eof),
        .out_len   (out_len),
        .err_valid (err_valid),
        .err_code  (err_code),
        .busy      (busy)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       sof;
        logic       eof;
        logic [7:0] len;
    } beat_t;

    // Bytes are listed left to right starting at b[63:56]; off is the SYNC position.
    typedef struct packed {
        logic [3:0]  nb;
        logic [2:0]  off;
        logic        good;
        logic [1:0]  code;
        logic [63:0] b;
    } vec_t;

    beat_t      exp_q[$];
    logic [1:0] err_q[$];
    beat_t      exp_beat;
    logic [1:0] exp_err;
    int         checks   = 0;
    int         failures = 0;
    vec_t       vecs[9];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // Scoreboard side: every accepted beat and every error pulse is popped and compared.
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat got data=%0h sof=%0b eof=%0b exp none", out_data, out_sof, out_eof);
            end else begin
                exp_beat = exp_q.pop_front();
                check("beat", 32'({out_data, out_sof, out_eof, out_len}), 32'(exp_beat));
            end
        end
        if (err_valid === 1'b1) begin
            if (err_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_err got code=%0d exp none", err_code);
            end else begin
                exp_err = err_q.pop_front();
                check("err_code", 32'(err_code), 32'(exp_err));
            end
        end
    end

    task automatic push_beat(input logic [7:0] d, input logic s, input logic e, input logic [7:0] l);
        beat_t bt;
        bt.data = d;
        bt.sof  = s;
        bt.eof  = e;
        bt.len  = l;
        exp_q.push_back(bt);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_done = 1'b1;
        rx_data = b;
        @(posedge clk);
        #1;
        rx_done = 1'b0;
    endtask

    task automatic run_ticks(input int n);
        tick = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (n < budget && (exp_q.size() != 0 || err_q.size() != 0 || busy || out_valid)) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (n >= budget) begin
            checks++;
            failures++;
            $display("FAIL wait_idle timeout got pending_beats=%0d pending_errs=%0d busy=%0b exp idle",
                     exp_q.size(), err_q.size(), busy);
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic [7:0] bb[8];
        logic [7:0] ln;
        int         o;
        for (int i = 0; i < 8; i++) bb[i] = v.b[63-8*i -: 8];
        o = int'(v.off);
        if (v.good) begin
            ln = bb[o+2];
            push_beat(bb[o+1], 1'b1, ln == 8'd0, ln);
            for (int j = 0; j < int'(ln); j++) push_beat(bb[o+3+j], 1'b0, j == int'(ln) - 1, ln);
        end else begin
            err_q.push_back(v.code);
        end
        for (int i = 0; i < int'(v.nb); i++) send_byte(bb[i]);
        wait_idle(200);
    endtask

    initial begin
        logic [7:0] c;
        logic [7:0] p;

        vecs[0] = '{nb: 4'd6, off: 3'd0, good: 1'b1, code: 2'd0, b: 64'hA5_10_02_33_44_65_00_00};
        vecs[1] = '{nb: 4'd4, off: 3'd0, good: 1'b1, code: 2'd0, b: 64'hA5_20_00_20_00_00_00_00};
        vecs[2] = '{nb: 4'd5, off: 3'd0, good: 1'b0, code: 2'd1, b: 64'hA5_10_01_55_00_00_00_00};
        vecs[3] = '{nb: 4'd5, off: 3'd0, good: 1'b1, code: 2'd0, b: 64'hA5_30_01_AA_9B_00_00_00};
        vecs[4] = '{nb: 4'd6, off: 3'd0, good: 1'b0, code: 2'd1, b: 64'hA5_10_02_33_44_67_00_00};
        vecs[5] = '{nb: 4'd3, off: 3'd0, good: 1'b0, code: 2'd2, b: 64'hA5_10_11_00_00_00_00_00};
        vecs[6] = '{nb: 4'd7, off: 3'd0, good: 1'b1, code: 2'd0, b: 64'hA5_40_03_01_02_03_43_00};
        vecs[7] = '{nb: 4'd5, off: 3'd1, good: 1'b1, code: 2'd0, b: 64'h00_A5_21_00_21_00_00_00};
        vecs[8] = '{nb: 4'd5, off: 3'd0, good: 1'b1, code: 2'd0, b: 64'hA5_A5_01_A5_01_00_00_00};

        rst       = 1'b1;
        tick      = 1'b0;
        rx_done   = 1'b0;
        rx_data   = 8'h00;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sof", 32'(out_sof), 32'd0);
        check("rst_out_eof", 32'(out_eof), 32'd0);
        check("rst_err_valid", 32'(err_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_len", 32'(out_len), 32'd0);
        check("rst_err_code", 32'(err_code), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Maximum legal length.
        push_beat(8'h5C, 1'b1, 1'b0, 8'd16);
        c = 8'h5C ^ 8'd16;
        for (int j = 0; j < 16; j++) begin
            p = 8'(j * 7 + 1);
            push_beat(p, 1'b0, j == 15, 8'd16);
            c = c ^ p;
        end
        send_byte(8'hA5);
        send_byte(8'h5C);
        send_byte(8'd16);
        for (int j = 0; j < 16; j++) send_byte(8'(j * 7 + 1));
        send_byte(c);
        wait_idle(400);

        // Timeout: the 640th tick without a byte abandons the frame.
        send_byte(8'hA5);
        send_byte(8'h10);
        run_ticks(639);
        check("tmo_busy_before", 32'(busy), 32'd1);
        err_q.push_back(2'd3);
        run_ticks(1);
        check("tmo_busy_after", 32'(busy), 32'd0);
        wait_idle(20);

        // Byte coinciding with the terminal tick wins.
        send_byte(8'hA5);
        send_byte(8'h10);
        run_ticks(639);
        tick    = 1'b1;
        rx_done = 1'b1;
        rx_data = 8'h00;
        @(posedge clk);
        #1;
        tick    = 1'b0;
        rx_done = 1'b0;
        check("tmo_race_busy", 32'(busy), 32'd1);
        push_beat(8'h10, 1'b1, 1'b1, 8'd0);
        send_byte(8'h10);
        wait_idle(20);

        // Stall with an overrun byte; beat 0 must hold.
        out_ready = 1'b0;
        push_beat(8'h10, 1'b1, 1'b0, 8'd2);
        push_beat(8'h33, 1'b0, 1'b0, 8'd2);
        push_beat(8'h44, 1'b0, 1'b1, 8'd2);
        err_q.push_back(2'd0);
        send_byte(8'hA5);
        send_byte(8'h10);
        send_byte(8'h02);
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'h65);
        for (int i = 0; i < 5; i++) begin
            rx_done = (i == 2);
            rx_data = 8'h7F;
            @(posedge clk);
            #1;
            check("stall_beat", 32'({out_valid, out_data, out_sof, out_eof, out_len}),
                  32'({1'b1, 8'h10, 1'b1, 1'b0, 8'd2}));
        end
        rx_done   = 1'b0;
        out_ready = 1'b1;
        wait_idle(50);

        // Reset mid-payload: nothing emitted, remaining bytes fall into HUNT.
        send_byte(8'hA5);
        send_byte(8'h10);
        send_byte(8'h03);
        send_byte(8'h01);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        send_byte(8'h02);
        send_byte(8'h03);
        check("midrst_still_idle", 32'(busy), 32'd0);
        run_vec(vecs[0]);

        repeat (3) @(posedge clk);
        #1;
        check("queues_empty", 32'(exp_q.size() + err_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
